leiwand_rv32_wb_arbiter: RTL
============================

# leiwand_rv32_wb_arbiter

Two-master, one-slave Wishbone (pipelined) arbiter between the leiwand_rv32 core bus port and a second master (debug/DMA loader), driving the single system bus. Round-robin grant, held for a master's whole `cyc` window. A per-transfer watchdog aborts a granted cycle that receives no `ack` within a programmable limit and reports it to the owning master via `err`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles without `i_ack` before abort; 0 disables watchdog.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset.
- `i_m0_cyc`, `i_m0_stb`, `i_m0_we`  in  1 each  master 0 (core) bus cycle, strobe, write enable.
- `i_m0_addr`, `i_m0_data`  in  `MEM_WIDTH`  master 0 address, write data.
- `o_m0_ack`, `o_m0_stall`, `o_m0_err`  out  1 each  master 0 ack, stall, abort error.
- `o_m0_data`  out  `MEM_WIDTH`  master 0 read data.
- `i_m1_*` / `o_m1_*`: same set for master 1.
- `o_cyc`, `o_stb`, `o_we`  out  1 each  slave-side cycle, strobe, write enable.
- `o_addr`, `o_data`  out  `MEM_WIDTH`  slave address, write data.
- `i_ack`, `i_stall`  in  1 each  slave ack, stall.
- `i_data`  in  `MEM_WIDTH`  slave read data.

## Operation
- States: IDLE, BUSY0, BUSY1, ABORT. Registers: state, `last` (last granted master), watchdog counter.
- IDLE: slave `o_cyc`/`o_stb`/`o_we` = 0, `o_addr`/`o_data` = 0; both masters see `stall`=1, `ack`=0, `err`=0.
- IDLE, exactly one `i_mk_cyc`=1 → BUSYk; both → BUSYk with k != `last`. `last` <= k on every grant.
- BUSYk: master k's `cyc`,`stb`,`we`,`addr`,`data` drive the slave combinationally; `o_mk_ack`=`i_ack`, `o_mk_stall`=`i_stall`. The other master sees `stall`=1, `ack`=0.
- `o_m0_data` = `o_m1_data` = `i_data` always. Masters qualify read data with `ack`.
- BUSYk, `i_mk_cyc`=0 → IDLE (release). Slave `o_cyc` falls in the same cycle, since it follows the master combinationally.
- Watchdog in BUSYk:
  - Counter clears on `i_ack`=1 or on entry to BUSYk; otherwise it increments.
  - Counter == `TIMEOUT_CYCLES`-1 with `i_ack`=0 → ABORT.
- ABORT (one cycle): slave `o_cyc`=`o_stb`=0; `o_mk_err`=1, `o_mk_stall`=1, `o_mk_ack`=0; next state IDLE.
- Master k must drop `cyc` after `err`. If it still holds `cyc` in IDLE, it re-arbitrates normally; round-robin favours the other master.
- Reset from any state: state=IDLE, `last`=1 (master 0 wins the first tie), counter=0. Slave outputs are 0 in the reset cycle's following cycle; any in-flight cycle is dropped without `ack`/`err`.
- Widths: counter is `HIGH_BIT_TO_FIT(TIMEOUT_CYCLES)`+1 bits. No data-width conversion.

## Timing
- Grant latency: `cyc` rises in cycle t while IDLE → BUSYk at t+1; the first slave `stb` is visible at t+1. Zero added latency on `ack`/`stall`/data while granted.
- Back-to-back: release at t → IDLE at t+1 → the other master is granted at t+2. Minimum one idle bus cycle between owners.
- Simultaneous events:
  - `i_ack`=1 on the expiry cycle: no abort.
  - Master drops `cyc` on the expiry cycle: release wins, no `err`.
  - `i_rst` overrides everything.
- `TIMEOUT_CYCLES`=0: ABORT is unreachable.

## Structure
- `MEM_WIDTH` and `HIGH_BIT_TO_FIT` come from `leiwand_rv32_constants.v` / `helper.v`. The state encoding (`ARB_IDLE`, `ARB_BUSY0`, `ARB_BUSY1`, `ARB_ABORT`) is added to `leiwand_rv32_constants.v`.
- One sub-module: `leiwand_rv32_wb_watchdog`.
  - Inputs: `i_clk`, `i_rst`, `i_clear`, `i_run`.
  - Output: `o_expired`, asserted combinationally when count == `TIMEOUT_CYCLES`-1 && `i_run`.
  - Parameter: `TIMEOUT_CYCLES`.

## Test plan
- Single request: m0 raises `cyc`+`stb` to read `addr` 0x10000000; slave acks 2 cycles later with 0x00000013 → slave `o_cyc` rises 1 cycle after the request, `o_m0_ack`=1 with `o_m0_data`=0x00000013; m1 sees `stall`=1 throughout.
- Tie after reset: m0 and m1 raise `cyc` in the same cycle → m0 granted first. After m0 releases, m1 is granted exactly 2 cycles after m0's `cyc` falls.
- Round-robin: both masters hold `cyc` and each completes one transfer, then releases and re-requests immediately → grants alternate m0, m1, m0, m1.
- Watchdog: `TIMEOUT_CYCLES`=4, m1 granted, slave never acks → ABORT on the 4th cycle after grant, `o_m1_err` pulses for 1 cycle, `o_cyc`=0, IDLE next cycle. Repeat with `i_ack` on the 4th cycle → no `err`.
- Slave stall: m0 write 0xDEADBEEF to 0x20000000 with `i_stall` high for 3 cycles → `o_m0_stall` mirrors `i_stall`; `o_data`=0xDEADBEEF held stable; single `ack` delivered to m0 only.
- Reset mid-transfer: assert `i_rst` while BUSY0 → next cycle `o_cyc`=`o_stb`=0, no `ack`/`err`. After reset deasserts, the first tie is granted to m0.

Source files
------------

// File: rtl/leiwand_rv32_wb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Bus width, FSM state encoding and the counter-sizing helper.
package leiwand_rv32_wb_arbiter_pkg;

    localparam int unsigned MemWidth = 32;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbBusy0 = 2'd1,
        ArbBusy1 = 2'd2,
        ArbAbort = 2'd3
    } arb_state_e;

    // Index of the most significant set bit; 0 for an input of 0 or 1.
    function automatic int unsigned high_bit_to_fit(input int unsigned value);
        int unsigned hb;
        hb = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (value[i]) hb = i;
        end
        return hb;
    endfunction

endpackage

// File: rtl/leiwand_rv32_wb_arbiter_if.sv
// Pipelined Wishbone bundle: master/slave views carry err, sys is the plain system-bus view.
interface leiwand_rv32_wb_arbiter_if
    import leiwand_rv32_wb_arbiter_pkg::*;
;
    logic                cyc;
    logic                stb;
    logic                we;
    logic [MemWidth-1:0] addr;
    logic [MemWidth-1:0] wdata;
    logic [MemWidth-1:0] rdata;
    logic                ack;
    logic                stall;
    logic                err;

    modport master (output cyc, stb, we, addr, wdata, input rdata, ack, stall, err);
    modport slave  (input cyc, stb, we, addr, wdata, output rdata, ack, stall, err);
    modport sys    (output cyc, stb, we, addr, wdata, input rdata, ack, stall);

endinterface

// File: rtl/leiwand_rv32_wb_watchdog.sv
// Per-transfer ack watchdog: counts running cycles since the last clear and flags
// the cycle on which the limit is reached. A limit of 0 never expires.
module leiwand_rv32_wb_watchdog
    import leiwand_rv32_wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int unsigned CntW = high_bit_to_fit(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_run) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (TIMEOUT_CYCLES == 0) begin : g_disabled
        assign o_expired = 1'b0;
    end else begin : g_enabled
        assign o_expired = i_run && (cnt_q == Limit);
    end

endmodule

// File: rtl/leiwand_rv32_wb_arbiter.sv
// Round-robin arbiter between the core bus port (m0) and a debug/DMA master (m1).
// Grant is held for the owner's whole cyc window; a stuck transfer is aborted with err.
module leiwand_rv32_wb_arbiter
    import leiwand_rv32_wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                       i_clk,
    input logic                       i_rst,
    leiwand_rv32_wb_arbiter_if.slave  m0_io,
    leiwand_rv32_wb_arbiter_if.slave  m1_io,
    leiwand_rv32_wb_arbiter_if.sys    bus_io
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       busy;
    logic       expired;

    assign busy = (state_q == ArbBusy0) || (state_q == ArbBusy1);

    // Held clear while not granted, so every grant starts counting from zero.
    leiwand_rv32_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (bus_io.ack || !busy),
        .i_run    (busy),
        .o_expired(expired)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ArbIdle: begin
                if (m0_io.cyc && m1_io.cyc) begin
                    state_d = last_q ? ArbBusy0 : ArbBusy1;
                    last_d  = ~last_q;
                end else if (m0_io.cyc) begin
                    state_d = ArbBusy0;
                    last_d  = 1'b0;
                end else if (m1_io.cyc) begin
                    state_d = ArbBusy1;
                    last_d  = 1'b1;
                end
            end
            ArbBusy0: begin
                if (!m0_io.cyc) begin
                    state_d = ArbIdle;
                end else if (expired && !bus_io.ack) begin
                    state_d = ArbAbort;
                end
            end
            ArbBusy1: begin
                if (!m1_io.cyc) begin
                    state_d = ArbIdle;
                end else if (expired && !bus_io.ack) begin
                    state_d = ArbAbort;
                end
            end
            ArbAbort: state_d = ArbIdle;
            default:  state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ArbIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        bus_io.cyc   = 1'b0;
        bus_io.stb   = 1'b0;
        bus_io.we    = 1'b0;
        bus_io.addr  = '0;
        bus_io.wdata = '0;
        m0_io.ack    = 1'b0;
        m0_io.stall  = 1'b1;
        m0_io.err    = 1'b0;
        m1_io.ack    = 1'b0;
        m1_io.stall  = 1'b1;
        m1_io.err    = 1'b0;
        m0_io.rdata  = bus_io.rdata;
        m1_io.rdata  = bus_io.rdata;
        unique case (state_q)
            ArbBusy0: begin
                bus_io.cyc   = m0_io.cyc;
                bus_io.stb   = m0_io.stb;
                bus_io.we    = m0_io.we;
                bus_io.addr  = m0_io.addr;
                bus_io.wdata = m0_io.wdata;
                m0_io.ack    = bus_io.ack;
                m0_io.stall  = bus_io.stall;
            end
            ArbBusy1: begin
                bus_io.cyc   = m1_io.cyc;
                bus_io.stb   = m1_io.stb;
                bus_io.we    = m1_io.we;
                bus_io.addr  = m1_io.addr;
                bus_io.wdata = m1_io.wdata;
                m1_io.ack    = bus_io.ack;
                m1_io.stall  = bus_io.stall;
            end
            // last_q still names the owner of the aborted transfer.
            ArbAbort: begin
                if (last_q) begin
                    m1_io.err = 1'b1;
                end else begin
                    m0_io.err = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
